muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the execute-stage ALU. It accepts one M-extension operation at a time, sequences a 32-step shift-add multiply or restoring divide, and holds a stall to the hazard logic while busy. It returns a single-cycle result pulse that the execute stage muxes into alu_result_e.

---
 rtl/riscv_m_pkg.sv | 28 ++
 rtl/muldiv_unit_sign_fix.sv | 54 +++++
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 encodings, the multiply/divide sequencer
// states and the architectural divide-by-zero quotient.
package riscv_m_pkg;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  // funct3[2] separates the divide/remainder group from the multiplies
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Sign handling around the unsigned iterative core: operand magnitudes on
// entry, and negate plus half/quotient/remainder select on exit.
module muldiv_sign_fix
  import riscv_m_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   op_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] a_mag,
  output logic [W-1:0] b_mag,
  output logic         neg_q,
  output logic         neg_r,
  input  logic [2:0]   op,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic         q_neg,
  input  logic         r_neg,
  output logic [W-1:0] result
);

  logic         a_signed;
  logic         b_signed;
  logic         a_s;
  logic         b_s;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;

  always_comb begin
    a_signed = (op_in != MULHU_F3) && (op_in != DIVU_F3) && (op_in != REMU_F3);
    b_signed = (op_in == MUL_F3) || (op_in == MULH_F3) ||
               (op_in == DIV_F3) || (op_in == REM_F3);
    a_s   = a_signed & a_in[W-1];
    b_s   = b_signed & b_in[W-1];
    a_mag = a_s ? (~a_in + 1'b1) : a_in;
    b_mag = b_s ? (~b_in + 1'b1) : b_in;
    neg_q = a_s ^ b_s;
    neg_r = a_s;
  end

  // Divide leaves the quotient in lo and the remainder in hi
  always_comb begin
    prod     = {hi, lo};
    prod_fix = q_neg ? (~prod + 1'b1) : prod;
    case (op)
      MUL_F3:                       result = prod_fix[W-1:0];
      MULH_F3, MULHSU_F3, MULHU_F3: result = prod_fix[2*W-1:W];
      DIV_F3, DIVU_F3:              result = q_neg ? (~lo + 1'b1) : lo;
      default:                      result = r_neg ? (~hi + 1'b1) : hi;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide beside the execute-stage ALU: 32-step
// shift-add multiply or restoring divide, with a pipeline stall while busy.
module muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  state_e         state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic [W-1:0]   dvsr;
  logic [2:0]     op;
  logic           q_neg;
  logic           r_neg;

  logic           accept;
  logic           div_zero;
  logic           div_ovf;
  logic [W-1:0]   special_res;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic           neg_q;
  logic           neg_r;
  logic [W-1:0]   fix_res;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;

  muldiv_sign_fix #(.W(W)) u_sign_fix (
    .op_in  (funct3_i),
    .a_in   (a_i),
    .b_in   (b_i),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .neg_q  (neg_q),
    .neg_r  (neg_r),
    .op     (op),
    .hi     (hi),
    .lo     (lo),
    .q_neg  (q_neg),
    .r_neg  (r_neg),
    .result (fix_res)
  );

  always_comb begin
    accept   = (state == IDLE) && start_i && !flush_i;
    div_zero = is_div_op(funct3_i) && (b_i == '0);
    div_ovf  = ((funct3_i == DIV_F3) || (funct3_i == REM_F3)) &&
               (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == {W{1'b1}});
    // Overflow quotient equals the dividend itself; remainders differ by case
    if (div_zero)
      special_res = funct3_i[1] ? a_i : DIV_BY_ZERO_Q[W-1:0];
    else
      special_res = funct3_i[1] ? '0 : a_i;
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : '0);
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, dvsr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      dvsr     <= '0;
      op       <= MUL_F3;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            op    <= funct3_i;
            q_neg <= neg_q;
            r_neg <= neg_r;
            hi    <= '0;
            if (div_zero || div_ovf) begin
              result_o <= special_res;
              state    <= DONE;
            end else begin
              lo    <= is_div_op(funct3_i) ? a_mag : b_mag;
              dvsr  <= is_div_op(funct3_i) ? b_mag : a_mag;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            if (is_div_op(op)) begin
              hi <= div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
              lo <= {lo[W-2:0], ~div_diff[W]};
            end else begin
              {hi, lo} <= {mul_sum, lo[W-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ITER)
              state <= FIX;
          end
        end
        FIX: begin
          cnt <= '0;
          if (flush_i) begin
            state <= IDLE;
          end else begin
            result_o <= fix_res;
            state    <= DONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy_o  = (state != IDLE);
    done_o  = (state == DONE) && !flush_i;
    stall_o = accept || (((state == RUN) || (state == FIX)) && !flush_i);
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, stall window, special
// divide cases, flush, ignored restart and mid-operation reset.
module tb_muldiv_unit;
  import riscv_m_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // Presents one op for a single cycle; returns stall_o seen on the accept cycle
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic stall_acc);
    @(negedge clk);
    funct3_i = f; a_i = a; b_i = b; start_i = 1'b1;
    #1 stall_acc = stall_o;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Observes n cycles after the accept edge; cycle k is sampled at the k-th negedge
  task automatic watch(input int n, output int n_done, output int done_k,
                       output int n_stall, output logic [31:0] res);
    n_done = 0; done_k = -1; n_stall = 0; res = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (stall_o) n_stall++;
      if (done_o) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          res = result_o;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; funct3_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done_o); end
    vectors++; if (result_o !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 00000000", result_o); end
  endtask

  task automatic test_mul();
    logic sa; int nd, dk, ns; logic [31:0] r;
    issue(MUL_F3, 32'd7, 32'hFFFF_FFFD, sa);
    watch(40, nd, dk, ns, r);
    vectors++; if (sa !== 1'b1) begin miscompares++; $display("FAIL mul_accept_stall got %b want 1", sa); end
    vectors++; if (ns != 33) begin miscompares++; $display("FAIL mul_stall_cycles got %0d want 33", ns); end
    vectors++; if (dk != 34) begin miscompares++; $display("FAIL mul_done_cycle got %0d want 34", dk); end
    vectors++; if (nd != 1) begin miscompares++; $display("FAIL mul_done_count got %0d want 1", nd); end
    vectors++; if (r !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mul_result got %h want ffffffeb", r); end
    vectors++; if (result_o !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mul_result_hold got %h want ffffffeb", result_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL mul_idle_after got %b want 0", busy_o); end
  endtask

  task automatic test_mul_high();
    logic [2:0] fs [3];
    logic [31:0] ex [3];
    logic sa; int nd, dk, ns; logic [31:0] r;
    fs[0] = MULHU_F3;  ex[0] = 32'hFFFF_FFFE;
    fs[1] = MULH_F3;   ex[1] = 32'h0000_0000;
    fs[2] = MULHSU_F3; ex[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      issue(fs[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, sa);
      watch(40, nd, dk, ns, r);
      vectors++; if (r !== ex[i]) begin miscompares++; $display("FAIL mulhigh_result f3=%0d got %h want %h", fs[i], r, ex[i]); end
      vectors++; if (dk != 34) begin miscompares++; $display("FAIL mulhigh_done f3=%0d got %0d want 34", fs[i], dk); end
    end
  endtask

  task automatic test_div_zero();
    logic [2:0] fs [4];
    logic [31:0] ex [4];
    logic sa; int nd, dk, ns; logic [31:0] r;
    fs[0] = DIV_F3;  ex[0] = 32'hFFFF_FFFF;
    fs[1] = REM_F3;  ex[1] = 32'h0000_0064;
    fs[2] = DIVU_F3; ex[2] = 32'hFFFF_FFFF;
    fs[3] = REMU_F3; ex[3] = 32'h0000_0064;
    for (int i = 0; i < 4; i++) begin
      issue(fs[i], 32'h64, 32'h0, sa);
      watch(6, nd, dk, ns, r);
      vectors++; if (r !== ex[i]) begin miscompares++; $display("FAIL divzero_result f3=%0d got %h want %h", fs[i], r, ex[i]); end
      vectors++; if (dk != 1) begin miscompares++; $display("FAIL divzero_done f3=%0d got %0d want 1", fs[i], dk); end
      vectors++; if (ns != 0) begin miscompares++; $display("FAIL divzero_stall f3=%0d got %0d want 0", fs[i], ns); end
      vectors++; if (sa !== 1'b1) begin miscompares++; $display("FAIL divzero_accept_stall f3=%0d got %b want 1", fs[i], sa); end
    end
  endtask

  task automatic test_signed_div();
    logic [2:0] fs [5];
    logic [31:0] as [5];
    logic [31:0] bs [5];
    logic [31:0] ex [5];
    int lat [5];
    logic sa; int nd, dk, ns; logic [31:0] r;
    fs[0] = DIV_F3;  as[0] = 32'h8000_0000; bs[0] = 32'hFFFF_FFFF; ex[0] = 32'h8000_0000; lat[0] = 1;
    fs[1] = REM_F3;  as[1] = 32'h8000_0000; bs[1] = 32'hFFFF_FFFF; ex[1] = 32'h0000_0000; lat[1] = 1;
    fs[2] = DIV_F3;  as[2] = 32'hFFFF_FFF9; bs[2] = 32'd2;         ex[2] = 32'hFFFF_FFFD; lat[2] = 34;
    fs[3] = REM_F3;  as[3] = 32'hFFFF_FFF9; bs[3] = 32'd2;         ex[3] = 32'hFFFF_FFFF; lat[3] = 34;
    fs[4] = DIVU_F3; as[4] = 32'hFFFF_FFF9; bs[4] = 32'd2;         ex[4] = 32'h7FFF_FFFC; lat[4] = 34;
    for (int i = 0; i < 5; i++) begin
      issue(fs[i], as[i], bs[i], sa);
      watch(40, nd, dk, ns, r);
      vectors++; if (r !== ex[i]) begin miscompares++; $display("FAIL sdiv_result case%0d got %h want %h", i, r, ex[i]); end
      vectors++; if (dk != lat[i]) begin miscompares++; $display("FAIL sdiv_done case%0d got %0d want %0d", i, dk, lat[i]); end
    end
  endtask

  task automatic test_flush();
    logic sa; int nd, dk, ns; logic [31:0] r;
    issue(DIVU_F3, 32'd1000, 32'd3, sa);
    for (int k = 1; k <= 11; k++) @(negedge clk);
    flush_i = 1'b1;
    #1;
    vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %b want 0", stall_o); end
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL flush_busy_before got %b want 1", busy_o); end
    @(posedge clk);
    #1 flush_i = 1'b0;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_idle got %b want 0", busy_o); end
    watch(40, nd, dk, ns, r);
    vectors++; if (nd != 0) begin miscompares++; $display("FAIL flush_no_done got %0d want 0", nd); end
    issue(DIVU_F3, 32'd100, 32'd7, sa);
    watch(40, nd, dk, ns, r);
    vectors++; if (r !== 32'd14) begin miscompares++; $display("FAIL flush_divu got %h want 0000000e", r); end
    issue(REMU_F3, 32'd100, 32'd7, sa);
    watch(40, nd, dk, ns, r);
    vectors++; if (r !== 32'd2) begin miscompares++; $display("FAIL flush_remu got %h want 00000002", r); end
  endtask

  task automatic test_back_to_back();
    logic sa; int nd, dk; logic [31:0] r;
    issue(MUL_F3, 32'd7, 32'hFFFF_FFFD, sa);
    nd = 0; dk = -1; r = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_o) begin nd++; if (dk < 0) begin dk = k; r = result_o; end end
      if (k == 5) begin funct3_i = DIVU_F3; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1; end
      if (k == 6) start_i = 1'b0;
    end
    vectors++; if (nd != 1) begin miscompares++; $display("FAIL b2b_done_count got %0d want 1", nd); end
    vectors++; if (dk != 34) begin miscompares++; $display("FAIL b2b_done_cycle got %0d want 34", dk); end
    vectors++; if (r !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL b2b_result got %h want ffffffeb", r); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL b2b_not_queued got %b want 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    logic sa; int nd, dk, ns; logic [31:0] r;
    issue(MULHU_F3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sa);
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
    vectors++; if (result_o !== 32'h0) begin miscompares++; $display("FAIL rstmid_result got %h want 00000000", result_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b want 0", done_o); end
    watch(40, nd, dk, ns, r);
    vectors++; if (nd != 0) begin miscompares++; $display("FAIL rstmid_no_done got %0d want 0", nd); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div_zero();
    test_signed_div();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
